// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// and the storage index-width helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-index width for a given storage depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core (master) and
// the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational lane steering for one 32-bit storage word: extended load data,
// plus byte enables and the merged word for stores.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lane_data;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the enables alone pick the target bytes.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en   = 4'b1111;
        lane_data = wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = wdata;
      end
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) merged_word[8*k +: 8] = lane_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait
// states, internal byte-lane merging for stores, extended load data.
//
// state | meaning
// IDLE  | req_ready=1, accept and capture a request
// WAIT  | counting wait states down to 0
// RESP  | rsp_valid=1, hold result until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               cur_write;
  logic [1:0]         cur_size;
  logic               cur_uns;
  logic [WIDTH-1:0]   cur_addr;
  logic [WIDTH-1:0]   cur_wdata;
  logic [IDX_W-1:0]   word_idx;
  logic               idx_in_range;
  logic               req_err;
  logic               enter_resp;
  logic               mem_we;
  logic [31:0]        rd_word;
  logic [31:0]        load_data;
  logic [31:0]        merged_word;
  logic [3:0]         byte_en;

  // With zero wait states the accepting edge is also the commit edge, so the
  // datapath works from the live request while IDLE and from the captured copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = bus.req_write;
      cur_size  = bus.req_size;
      cur_uns   = bus.req_unsigned;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_write = wr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign word_idx     = cur_addr[IDX_W+1:2];
  assign idx_in_range = ({1'b0, word_idx} < (IDX_W+1)'(DEPTH_WORDS));

  always_comb begin
    req_err = 1'b0;
    case (cur_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = cur_addr[0];
      SZ_WORD: req_err = (cur_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (!idx_in_range) req_err = 1'b1;
    if (cur_addr[WIDTH-1:IDX_W+2] != '0) req_err = 1'b1;
  end

  assign rd_word = idx_in_range ? mem_q[word_idx] : 32'h0;

  mem_lane_align u_align (
    .rd_word     (rd_word),
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .wdata       (cur_wdata[31:0]),
    .load_data   (load_data),
    .byte_en     (byte_en),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = req_err;
      rdata_d = (req_err || cur_write) ? '0 : WIDTH'(load_data);
    end
  end

  assign mem_we = enter_resp && cur_write && !req_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= merged_word;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
